pulse_stretch: RTL

- Output-conditioning counterpart to the input debouncer. It turns a single-cycle request tick (e.g. a debounced trigger tick or a game "hit" event) into a clean, fixed-width level pulse.
- Every pulse is followed by an enforced minimum low gap, so the external device it drives (recoil solenoid, LED, buzzer) never sees glitches or over-rapid retriggering.
- Sits between game logic and an output pin; a 1-deep request latch absorbs a request that arrives while busy.

---
 rtl/duck_io_pkg.sv | 19 +
 rtl/load_down_counter.sv | 26 ++
 rtl/pulse_stretch.sv | 120 ++++++++++++
 3 files changed

// File: rtl/duck_io_pkg.sv
// Shared constants for the duck I/O conditioning blocks: FSM state encoding
// and default timing for a 50 MHz system clock.
package duck_io_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_ON   = 2'b01;
    localparam logic [1:0] ST_GAP  = 2'b10;

    localparam int CLK_HZ         = 50000000;
    localparam int ON_CYCLES_DEF  = 2000000;   // 40 ms high
    localparam int GAP_CYCLES_DEF = 1000000;   // 20 ms enforced low

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_ON   = ST_ON,
        S_GAP  = ST_GAP
    } state_t;

endpackage

// File: rtl/load_down_counter.sv
// Loadable down counter that holds at zero; zero flags the final cycle of a phase.
module load_down_counter #(
    parameter int CW = 21
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          zero
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pulse_stretch.sv
// Stretches trig ticks into ON_CYCLES-wide pulses with a GAP_CYCLES low gap and a
// 1-deep request latch. Define PULSE_STRETCH_RETRIG_EN to let trig in ON extend the pulse.
module pulse_stretch
    import duck_io_pkg::*;
#(
    parameter int CW         = 21,
    parameter int ON_CYCLES  = ON_CYCLES_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic trig,
    output logic out_level,
    output logic busy,
    output logic done_tick,
    output logic drop_tick
);

    localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

    state_t        state, state_n;
    logic          pending, pending_n;
    logic          done_n, drop_n;
    logic          cnt_load, cnt_en, cnt_zero;
    logic [CW-1:0] cnt_load_val;
    logic [CW-1:0] cnt_unused;

    load_down_counter #(.CW(CW)) u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .count    (cnt_unused),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            pending   <= 1'b0;
            out_level <= 1'b0;
            busy      <= 1'b0;
            done_tick <= 1'b0;
            drop_tick <= 1'b0;
        end else begin
            state     <= state_n;
            pending   <= pending_n;
            out_level <= (state_n == S_ON);
            busy      <= (state_n != S_IDLE);
            done_tick <= done_n;
            drop_tick <= drop_n;
        end
    end

    always_comb begin
        state_n      = state;
        pending_n    = pending;
        done_n       = 1'b0;
        drop_n       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = ON_LOAD;
        cnt_en       = 1'b0;
        case (state)
            S_IDLE: begin
                if (trig) begin
                    state_n  = S_ON;
                    cnt_load = 1'b1;
                end
            end
            S_ON: begin
                cnt_en = 1'b1;
`ifdef PULSE_STRETCH_RETRIG_EN
                // A retrigger restarts the high time, even on the last ON cycle.
                if (trig) begin
                    cnt_load = 1'b1;
                end else if (cnt_zero) begin
                    state_n      = S_GAP;
                    cnt_load     = 1'b1;
                    cnt_load_val = GAP_LOAD;
                    done_n       = 1'b1;
                end
`else
                if (cnt_zero) begin
                    state_n      = S_GAP;
                    cnt_load     = 1'b1;
                    cnt_load_val = GAP_LOAD;
                    done_n       = 1'b1;
                end
                if (trig) begin
                    pending_n = 1'b1;
                    drop_n    = pending;
                end
`endif
            end
            S_GAP: begin
                cnt_en = 1'b1;
                if (cnt_zero) begin
                    // Final gap cycle: a live or latched request starts the next pulse directly.
                    if (pending || trig) begin
                        state_n   = S_ON;
                        cnt_load  = 1'b1;
                        pending_n = 1'b0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else if (trig) begin
                    pending_n = 1'b1;
                    drop_n    = pending;
                end
            end
            default: begin
                state_n   = S_IDLE;
                pending_n = 1'b0;
            end
        endcase
    end

endmodule
